egress_collector: RTL and testbench

Drains one output port of the switch DUT. Pulls addressed bytes across the port's read handshake (`valid_out`/`data_rd`/`addr_out`/`data_out`) into a first-word-fall-through FIFO. Discards bytes whose address is not this port's ID. Presents accepted words to the scoreboard/sink side on a valid/ready interface. One instance sits directly downstream of each DUT output port.

---
 rtl/egress_pkg.sv | 17 +
 rtl/egress_fifo.sv | 58 +++++
 rtl/egress_collector.sv | 117 +++++++++++
 tb/tb_egress_collector.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/egress_pkg.sv
// Shared types and constants for the egress collector and its FIFO.
package egress_pkg;

    localparam int EGRESS_DEFAULT_DEPTH = 8;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

endpackage

// File: rtl/egress_fifo.sv
// First-word-fall-through storage of word_t; head is always visible on o_rdata.
module egress_fifo
    import egress_pkg::*;
#(
    parameter int DEPTH = EGRESS_DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_clear,
    input  word_t                  i_wdata,
    output word_t                  o_rdata,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_empty,
    output logic                   o_full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    word_t         r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == FULL_CNT);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (!reset || i_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked solely by r_count.
    always_ff @(posedge clk) begin
        if (reset && !i_clear && w_do_push) r_mem[r_wptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/egress_collector.sv
// Drains one switch output port into a FWFT FIFO, filtering on PORT_ID.
// Optional saturating accept/drop counters are built when EGRESS_STATS_EN is defined.
module egress_collector
    import egress_pkg::*;
#(
    parameter int         DEPTH   = EGRESS_DEFAULT_DEPTH,
    parameter logic [7:0] PORT_ID = 8'h00
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   flush,
    input  logic                   valid_out,
    input  logic [7:0]             addr_out,
    input  logic [7:0]             data_out,
    output logic                   data_rd,
    output logic                   sink_valid,
    output logic [7:0]             sink_addr,
    output logic [7:0]             sink_data,
    input  logic                   sink_ready,
    output logic [$clog2(DEPTH):0] fifo_count,
    output state_e                 o_dbg_state,
    output logic                   mismatch_err
`ifdef EGRESS_STATS_EN
    ,
    output logic [15:0]            acc_cnt,
    output logic [15:0]            drop_cnt
`endif
);

    // Handshakes: a transfer happens at a rising edge where the producer's
    // valid and the consumer's ready/strobe are both high; nothing else moves data.

    state_e r_state;
    state_e w_next_state;
    logic   r_mismatch_err;
    logic   w_xfer;
    logic   w_push;
    logic   w_drop;
    logic   w_pop;
    logic   w_clear;
    logic   w_empty;
    logic   w_full;
    word_t  w_head;
    word_t  w_wdata;

    always_ff @(posedge clk) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = FLUSH;
        end else begin
            case (r_state)
                IDLE, RUN, FLUSH: w_next_state = enable ? RUN : IDLE;
                default:          w_next_state = IDLE;
            endcase
        end
    end

    assign data_rd    = (r_state == RUN) && !w_full;
    assign sink_valid = !w_empty && (r_state != FLUSH);

    // A flush edge discards whatever would have moved; the DUT still sees its read.
    assign w_xfer  = valid_out && data_rd;
    assign w_push  = w_xfer && (addr_out == PORT_ID) && !flush;
    assign w_drop  = w_xfer && (addr_out != PORT_ID);
    assign w_pop   = sink_valid && sink_ready && !flush;
    assign w_clear = flush || (r_state == FLUSH);
    assign w_wdata = '{addr: addr_out, data: data_out};

    egress_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (w_clear),
        .i_wdata (w_wdata),
        .o_rdata (w_head),
        .o_count (fifo_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    assign sink_addr = w_head.addr;
    assign sink_data = w_head.data;

    always_ff @(posedge clk) begin
        if (!reset)      r_mismatch_err <= 1'b0;
        else if (w_drop) r_mismatch_err <= 1'b1;
    end

    assign mismatch_err = r_mismatch_err;
    assign o_dbg_state  = r_state;

`ifdef EGRESS_STATS_EN
    logic [15:0] r_acc_cnt;
    logic [15:0] r_drop_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_acc_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push && (r_acc_cnt != 16'hFFFF))  r_acc_cnt  <= r_acc_cnt + 1'b1;
            if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign acc_cnt  = r_acc_cnt;
    assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_egress_collector.sv
// Directed bench for egress_collector: acts as the switch port and the sink.
module tb_egress_collector;
    import egress_pkg::*;

    localparam int         DEPTH   = 8;
    localparam logic [7:0] PID     = 8'h5A;
    localparam logic [7:0] BAD     = 8'h5B;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic         flush;
    logic         valid_out;
    logic [7:0]   addr_out;
    logic [7:0]   data_out;
    logic         data_rd;
    logic         sink_valid;
    logic [7:0]   sink_addr;
    logic [7:0]   sink_data;
    logic         sink_ready;
    logic [3:0]   fifo_count;
    state_e       dbg_state;
    logic         mismatch_err;
`ifdef EGRESS_STATS_EN
    logic [15:0]  acc_cnt;
    logic [15:0]  drop_cnt;
`endif

    int n_checks = 0;
    int n_err    = 0;
    logic [15:0] src_q[$];
    logic [15:0] exp_q[$];
    logic        lat_chk   = 1'b0;
    logic        prev_push = 1'b0;

    always #5 clk = ~clk;

    egress_collector #(.DEPTH(DEPTH), .PORT_ID(PID)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .flush        (flush),
        .valid_out    (valid_out),
        .addr_out     (addr_out),
        .data_out     (data_out),
        .data_rd      (data_rd),
        .sink_valid   (sink_valid),
        .sink_addr    (sink_addr),
        .sink_data    (sink_data),
        .sink_ready   (sink_ready),
        .fifo_count   (fifo_count),
        .o_dbg_state  (dbg_state),
        .mismatch_err (mismatch_err)
`ifdef EGRESS_STATS_EN
        ,
        .acc_cnt      (acc_cnt),
        .drop_cnt     (drop_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive source head, check sink word, advance at the edge.
    task automatic cycle();
        logic xfer;
        logic sxfer;
        if (src_q.size() > 0) begin
            valid_out = 1'b1;
            {addr_out, data_out} = src_q[0];
        end else begin
            valid_out = 1'b0;
        end
        #1;
        xfer  = valid_out && data_rd;
        sxfer = sink_valid && sink_ready;
        if (sxfer) chk("sink_word", {16'h0, sink_addr, sink_data},
                       {16'h0, (exp_q.size() > 0) ? exp_q[0] : 16'hxxxx});
        if (lat_chk) begin
            if (prev_push) chk("push_latency", {31'h0, sink_valid}, 32'd1);
            chk("count_le1", {31'h0, fifo_count <= 4'd1}, 32'd1);
        end
        @(posedge clk);
        #1;
        if (xfer) begin
            prev_push = (src_q[0][15:8] == PID);
            void'(src_q.pop_front());
        end else begin
            prev_push = 1'b0;
        end
        if (sxfer && exp_q.size() > 0) void'(exp_q.pop_front());
    endtask

    task automatic run_drain(input string tag, input int max);
        int n = 0;
        while ((src_q.size() > 0 || exp_q.size() > 0) && n < max) begin
            cycle();
            n++;
        end
        chk(tag, src_q.size() + exp_q.size(), 32'd0);
    endtask

    task automatic run_src(input string tag, input int max);
        int n = 0;
        while (src_q.size() > 0 && n < max) begin
            cycle();
            n++;
        end
        chk(tag, src_q.size(), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b0; enable = 1'b0; flush = 1'b0; sink_ready = 1'b0;
        src_q.delete(); exp_q.delete();
        prev_push = 1'b0;
        cycle(); cycle();
        reset = 1'b1;
    endtask

    task automatic start_run();
        enable = 1'b1;
        cycle();
    endtask

    initial begin
        valid_out = 1'b0; addr_out = '0; data_out = '0;
        do_reset();

        // Reset state
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        chk("rst_data_rd", {31'h0, data_rd}, 32'd0);
        chk("rst_sink_valid", {31'h0, sink_valid}, 32'd0);
        chk("rst_count", {28'h0, fifo_count}, 32'd0);
        chk("rst_err", {31'h0, mismatch_err}, 32'd0);
`ifdef EGRESS_STATS_EN
        chk("rst_acc", {16'h0, acc_cnt}, 32'd0);
        chk("rst_drop", {16'h0, drop_cnt}, 32'd0);
`endif

        // Back-to-back streaming, one-cycle latency
        start_run();
        chk("run_state", 32'(dbg_state), 32'(RUN));
        chk("run_data_rd", {31'h0, data_rd}, 32'd1);
        sink_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            src_q.push_back({PID, 8'h11 + 8'(i)});
            exp_q.push_back({PID, 8'h11 + 8'(i)});
        end
        lat_chk = 1'b1;
        run_drain("stream_drain", 20);
        lat_chk = 1'b0;
        chk("stream_err", {31'h0, mismatch_err}, 32'd0);

        // Fill to full with sink stalled, then drain all 10
        do_reset();
        start_run();
        for (int i = 0; i < 10; i++) begin
            src_q.push_back({PID, 8'h20 + 8'(i)});
            exp_q.push_back({PID, 8'h20 + 8'(i)});
        end
        for (int i = 0; i < 12; i++) cycle();
        chk("full_count", {28'h0, fifo_count}, 32'd8);
        chk("full_data_rd", {31'h0, data_rd}, 32'd0);
        chk("full_src_left", src_q.size(), 32'd2);
        sink_ready = 1'b1;
        run_drain("full_drain", 40);
        chk("full_end_count", {28'h0, fifo_count}, 32'd0);

        // Address filter
        do_reset();
        start_run();
        sink_ready = 1'b1;
        for (int i = 0; i < 6; i++)
            src_q.push_back({(i % 2 == 0) ? PID : BAD, 8'h31 + 8'(i)});
        exp_q.push_back({PID, 8'h31});
        exp_q.push_back({PID, 8'h33});
        exp_q.push_back({PID, 8'h35});
        run_drain("filter_drain", 30);
        chk("filter_err", {31'h0, mismatch_err}, 32'd1);
`ifdef EGRESS_STATS_EN
        chk("filter_acc", {16'h0, acc_cnt}, 32'd3);
        chk("filter_drop", {16'h0, drop_cnt}, 32'd3);
`endif

        // Flush with traffic present
        do_reset();
        start_run();
        src_q.push_back({BAD, 8'h40});
        for (int i = 0; i < 5; i++) src_q.push_back({PID, 8'h41 + 8'(i)});
        run_src("flush_fill", 20);
        chk("flush_pre_count", {28'h0, fifo_count}, 32'd5);
        src_q.push_back({PID, 8'h77});
        src_q.push_back({PID, 8'h78});
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("flush_state", 32'(dbg_state), 32'(FLUSH));
        chk("flush_count", {28'h0, fifo_count}, 32'd0);
        chk("flush_sink_valid", {31'h0, sink_valid}, 32'd0);
        chk("flush_data_rd", {31'h0, data_rd}, 32'd0);
        chk("flush_err_kept", {31'h0, mismatch_err}, 32'd1);
        cycle();
        chk("flush_no_read", src_q.size(), 32'd1);
        chk("flush_after_state", 32'(dbg_state), 32'(RUN));
        chk("flush_after_count", {28'h0, fifo_count}, 32'd0);
        chk("flush_after_rd", {31'h0, data_rd}, 32'd1);
`ifdef EGRESS_STATS_EN
        chk("flush_acc", {16'h0, acc_cnt}, 32'd5);
        chk("flush_drop", {16'h0, drop_cnt}, 32'd1);
`endif

        // Full FIFO under continuous push and pop
        do_reset();
        start_run();
        for (int i = 0; i < 8; i++) begin
            src_q.push_back({PID, 8'hA0 + 8'(i)});
            exp_q.push_back({PID, 8'hA0 + 8'(i)});
        end
        run_src("sat_fill", 20);
        chk("sat_full_count", {28'h0, fifo_count}, 32'd8);
        for (int i = 0; i < 10; i++) begin
            src_q.push_back({PID, 8'hB0 + 8'(i)});
            exp_q.push_back({PID, 8'hB0 + 8'(i)});
        end
        sink_ready = 1'b1;
        for (int n = 0; n < 40 && src_q.size() > 0; n++) begin
            cycle();
            chk("sat_count_hi", {31'h0, fifo_count >= 4'd7}, 32'd1);
        end
        run_drain("sat_drain", 40);
        chk("sat_end_count", {28'h0, fifo_count}, 32'd0);

        // Reset mid-stream
        do_reset();
        start_run();
        src_q.push_back({PID, 8'hC1});
        src_q.push_back({BAD, 8'hC2});
        src_q.push_back({PID, 8'hC3});
        src_q.push_back({PID, 8'hC4});
        run_src("mid_fill", 20);
        chk("mid_count", {28'h0, fifo_count}, 32'd3);
        src_q.push_back({PID, 8'hC5});
        reset = 1'b0;
        cycle();
        chk("mid_rst_state", 32'(dbg_state), 32'(IDLE));
        chk("mid_rst_count", {28'h0, fifo_count}, 32'd0);
        chk("mid_rst_sink_valid", {31'h0, sink_valid}, 32'd0);
        chk("mid_rst_data_rd", {31'h0, data_rd}, 32'd0);
        chk("mid_rst_err", {31'h0, mismatch_err}, 32'd0);
`ifdef EGRESS_STATS_EN
        chk("mid_rst_acc", {16'h0, acc_cnt}, 32'd0);
        chk("mid_rst_drop", {16'h0, drop_cnt}, 32'd0);
`endif
        reset = 1'b1;
        src_q.delete(); exp_q.delete();
        cycle();
        sink_ready = 1'b1;
        src_q.push_back({PID, 8'hD1});
        src_q.push_back({PID, 8'hD2});
        exp_q.push_back({PID, 8'hD1});
        exp_q.push_back({PID, 8'hD2});
        run_drain("mid_new_drain", 20);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
